// File: rtl/serial_mag_comparator.sv
// Bit-serial, cascadable magnitude comparator: walks A/B MSB-first through a 1-bit compare cell.
// Optional macro SERIAL_MAG_CMP_EARLY_EXIT_EN finishes as soon as the outcome is decided.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             l,
  input  logic             g,
  input  logic             e,
  output logic             busy,
  output logic             done,
  output logic             LT,
  output logic             GT,
  output logic             EQ
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Flag vectors are packed as {l, g, e}.
  function automatic logic [2:0] norm_flags(input logic li, input logic gi, input logic ei);
    logic [2:0] r;
    if (gi) begin
      r = 3'b010;
    end else if (li) begin
      r = 3'b100;
    end else if (ei) begin
      r = 3'b001;
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  // One 1-bit compare cell: a decided upstream (g or l) always wins over the local bits.
  function automatic logic [2:0] cmp_cell(input logic ai, input logic bi, input logic [2:0] lge);
    logic [2:0] r;
    if (lge[1]) begin
      r = 3'b010;
    end else if (lge[2]) begin
      r = 3'b100;
    end else if (lge[0]) begin
      if (ai && !bi) begin
        r = 3'b010;
      end else if (!ai && bi) begin
        r = 3'b100;
      end else begin
        r = 3'b001;
      end
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       flg_q, flg_d;
  logic [2:0]       res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       cell_s;
  logic             finish_s;

  // Next-state, datapath and result update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    flg_d    = flg_q;
    res_d    = res_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    finish_s = 1'b0;
    cell_s   = cmp_cell(a_q[WIDTH-1], b_q[WIDTH-1], flg_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          flg_d   = norm_flags(l, g, e);
          cnt_d   = CW'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        flg_d    = cell_s;
        a_d      = {a_q[WIDTH-2:0], 1'b0};
        b_d      = {b_q[WIDTH-2:0], 1'b0};
        finish_s = (cnt_q == {CW{1'b0}}) || (EARLY_EXIT && (cell_s[2] || cell_s[1]));
        if (finish_s) begin
          res_d   = cell_s;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      flg_q   <= 3'b000;
      res_q   <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      flg_q   <= flg_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign LT   = res_q[2];
  assign GT   = res_q[1];
  assign EQ   = res_q[0];

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Randomized self-checking bench for serial_mag_comparator against an arithmetic reference model.
module tb_serial_mag_comparator;

  localparam int W = 8;

`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         l = 1'b0;
  logic         g = 1'b0;
  logic         e = 1'b0;
  logic         busy, done, LT, GT, EQ;

  int checks = 0;
  int failures = 0;
  logic [2:0] prev_res = 3'b000;  // {LT,GT,EQ} the DUT should currently be holding

  serial_mag_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .l(l), .g(g), .e(e),
    .busy(busy), .done(done), .LT(LT), .GT(GT), .EQ(EQ)
  );

  always #5 clk = ~clk;

  // Expected {LT,GT,EQ}: upstream g beats l beats a numeric compare gated by e.
  function automatic logic [2:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic li, input logic gi, input logic ei);
    if (gi) return 3'b010;
    if (li) return 3'b100;
    if (!ei) return 3'b000;
    if (x > y) return 3'b010;
    if (x < y) return 3'b100;
    return 3'b001;
  endfunction

  // Clock edges from the accepting edge until done is visible.
  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic li, input logic gi, input logic ei);
    int d;
    if (!EARLY) return W;
    if (gi || li) return 1;
    if (!ei || x == y) return W;
    d = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (d == 0 && x[i] != y[i]) d = W - i;
    end
    return d;
  endfunction

  task automatic run_compare(input logic [W-1:0] xa, input logic [W-1:0] xb,
                             input logic tl, input logic tg, input logic te,
                             input string name, input bit poke);
    logic [2:0] exp_res;
    int exp_lat;
    int seen;
    exp_res = model_res(xa, xb, tl, tg, te);
    exp_lat = model_lat(xa, xb, tl, tg, te);
    @(negedge clk);
    a = xa; b = xb; l = tl; g = tg; e = te; start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after_accept: busy=%b done=%b expected busy=1 done=0", name, busy, done);
    end
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    {l, g, e} = 3'($urandom);
    seen = 0;
    for (int k = 1; k <= W + 4; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = k;
        break;
      end
      checks++;
      if ({LT, GT, EQ} !== prev_res || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s hold_in_shift k=%0d: res=%b busy=%b expected res=%b busy=1",
                 name, k, {LT, GT, EQ}, busy, prev_res);
      end
      if (poke) begin
        start = (k == 2);
        if (k == 2) begin
          a = ~xa; b = ~xb; l = ~tl; g = ~tg; e = ~te;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (seen != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d edges expected %0d", name, seen, exp_lat);
    end
    checks++;
    if ({LT, GT, EQ} !== exp_res || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s result: LT/GT/EQ=%b busy=%b expected %b busy=0", name, {LT, GT, EQ}, busy, exp_res);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {LT, GT, EQ} !== exp_res) begin
      failures++;
      $display("FAIL %s after_done: done=%b busy=%b res=%b expected 0 0 %b", name, done, busy, {LT, GT, EQ}, exp_res);
    end
    prev_res = exp_res;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, LT, GT, EQ} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_state: outputs=%b expected 00000", {busy, done, LT, GT, EQ});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, LT, GT, EQ} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_held: outputs=%b expected 00000", {busy, done, LT, GT, EQ});
    end
    @(negedge clk);
    rst = 1'b0;
    prev_res = 3'b000;
  endtask

  task automatic test_directed();
    run_compare(8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, "eq_a5", 1'b0);
    run_compare(8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, "gt_msb", 1'b0);
    run_compare(8'h12, 8'h13, 1'b0, 1'b0, 1'b1, "lt_lsb", 1'b0);
    run_compare(8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, "upstream_g", 1'b0);
    run_compare(8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, "no_flags", 1'b0);
    run_compare(8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, "upstream_l", 1'b0);
    run_compare(8'h40, 8'h40, 1'b1, 1'b1, 1'b1, "all_flags", 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] xa, xb;
    logic [2:0] f;
    for (int n = 0; n < 40; n++) begin
      xa = W'($urandom);
      case ($urandom_range(0, 2))
        0: xb = xa;
        1: xb = xa ^ W'(1 << $urandom_range(0, W - 1));
        default: xb = W'($urandom);
      endcase
      f = 3'($urandom);
      if ($urandom_range(0, 3) != 0) f = 3'b001;
      run_compare(xa, xb, f[2], f[1], f[0], "random", 1'b0);
    end
  endtask

  task automatic test_busy_ignore();
    run_compare(8'h12, 8'h13, 1'b0, 1'b0, 1'b1, "start_during_busy", 1'b1);
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    @(negedge clk);
    a = 8'h55; b = 8'h54; l = 1'b0; g = 1'b0; e = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, LT, GT, EQ} !== 5'b00000) begin
      failures++;
      $display("FAIL abort_async_clear: outputs=%b expected 00000", {busy, done, LT, GT, EQ});
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL abort_no_done: activity after abort=1 expected 0");
    end
    prev_res = 3'b000;
    run_compare(8'h3C, 8'h3D, 1'b0, 1'b0, 1'b1, "after_abort", 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa [3];
    logic [W-1:0] ob [3];
    logic [2:0]   er [3];
    int acc [3];
    int lat [3];
    int got_t [3];
    int dn;
    int cnt;
    oa[0] = 8'h10; ob[0] = 8'h20;
    oa[1] = 8'h20; ob[1] = 8'h10;
    oa[2] = 8'h33; ob[2] = 8'h33;
    for (int n = 0; n < 3; n++) begin
      er[n]  = model_res(oa[n], ob[n], 1'b0, 1'b0, 1'b1);
      lat[n] = model_lat(oa[n], ob[n], 1'b0, 1'b0, 1'b1);
      acc[n] = (n == 0) ? 0 : acc[n-1] + lat[n-1] + 2;
      got_t[n] = -1;
    end
    @(negedge clk);
    a = oa[0]; b = ob[0]; l = 1'b0; g = 1'b0; e = 1'b1; start = 1'b1;
    @(posedge clk);
    dn = 0;
    for (int t = 1; t <= acc[2] + lat[2] + 3; t++) begin
      @(negedge clk);
      cnt = 0;
      for (int j = 0; j < 3; j++) if (acc[j] < t) cnt++;
      if (cnt >= 3) begin
        start = 1'b0;
      end else begin
        a = oa[cnt]; b = ob[cnt];
      end
      @(posedge clk); #1;
      if (done === 1'b1 && dn < 3) begin
        got_t[dn] = t;
        checks++;
        if ({LT, GT, EQ} !== er[dn]) begin
          failures++;
          $display("FAIL b2b_result_%0d: LT/GT/EQ=%b expected %b", dn, {LT, GT, EQ}, er[dn]);
        end
        dn++;
      end
    end
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (got_t[n] != acc[n] + lat[n]) begin
        failures++;
        $display("FAIL b2b_done_time_%0d: got edge %0d expected edge %0d", n, got_t[n], acc[n] + lat[n]);
      end
    end
    prev_res = er[2];
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
